// File: rtl/macro_lane_serializer_if.sv
// ---------------------------------------------------------------------------
// macro_lane_serializer_if
//   Handshake bundle between a wide packed-word producer, the lane
//   serializer and a narrow per-lane consumer.
//
//   Signals
//     s_valid / s_ready / s_data   packed word side (INPUT_WIDTH*INPUT_COUNT)
//     m_valid / m_ready            lane side handshake
//     m_data                       current lane value (INPUT_WIDTH)
//     m_index                      current lane number (IDX_WIDTH)
//     m_last                       current lane is the final lane of the word
//     m_zero                       current lane value is all zero
//
//   Modports
//     slave   the serializer's view (accepts words, emits lanes)
//     master  the environment's view (drives words, consumes lanes)
// ---------------------------------------------------------------------------
interface macro_lane_serializer_if #(
  parameter int INPUT_WIDTH = 1,
  parameter int INPUT_COUNT = 1
);
  localparam int IDX_WIDTH = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;

  logic                               s_valid;
  logic                               s_ready;
  logic [INPUT_WIDTH*INPUT_COUNT-1:0] s_data;
  logic                               m_valid;
  logic                               m_ready;
  logic [INPUT_WIDTH-1:0]             m_data;
  logic [IDX_WIDTH-1:0]               m_index;
  logic                               m_last;
  logic                               m_zero;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_index, m_last, m_zero
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_index, m_last, m_zero
  );
endinterface

// File: rtl/macro_lane_serializer.sv
// ---------------------------------------------------------------------------
// macro_lane_serializer
//   Splits one packed word of INPUT_COUNT lanes into single-lane beats,
//   lane 0 first, each tagged with its index, a last flag and an all-zero
//   flag. A new word can be taken on the final-lane handshake, so a
//   continuous stream runs with no bubble between words.
//
//   Ports
//     clk      rising-edge clock
//     reset    synchronous, active-high reset
//     bus      macro_lane_serializer_if.slave (s_* word side, m_* lane side)
//
//   Optional feature (compile-time macro)
//     MACRO_LANE_SERIALIZER_SKIP_ZERO_EN
//       defined   : all-zero lanes are skipped; an all-zero word still emits
//                   one beat (index 0, m_zero=1, m_last=1)
//       undefined : every lane is emitted in order
//
//   State | meaning
//   ------+------------------------------------------
//   IDLE  | no word held, s_ready=1
//   SEND  | word held, m_valid=1, presenting one lane
// ---------------------------------------------------------------------------
module macro_lane_serializer #(
  parameter int INPUT_WIDTH = 1,
  parameter int INPUT_COUNT = 1
) (
  input logic                    clk,
  input logic                    reset,
  macro_lane_serializer_if.slave bus
);
  localparam int IDX_WIDTH = (INPUT_COUNT > 1) ? $clog2(INPUT_COUNT) : 1;
  localparam int DW        = INPUT_WIDTH * INPUT_COUNT;

  typedef logic [IDX_WIDTH-1:0] idx_t;
  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state;
  logic [DW-1:0]          word;
  idx_t                   idx;
  logic                   m_valid_q;
  logic [INPUT_WIDTH-1:0] m_data_q;
  logic                   m_last_q;

  logic                   load_now;
  idx_t                   ld_idx;
  logic                   ld_last;
  idx_t                   adv_idx;
  logic                   adv_last;

  function automatic logic [INPUT_WIDTH-1:0] lane_of(input logic [DW-1:0] w, input idx_t i);
    return w[int'(i)*INPUT_WIDTH +: INPUT_WIDTH];
  endfunction

`ifdef MACRO_LANE_SERIALIZER_SKIP_ZERO_EN
  logic [INPUT_COUNT-1:0] ld_mask;
  logic [INPUT_COUNT-1:0] word_mask;

  // Lowest nonzero lane at or above 'from'; 0 when there is none.
  function automatic idx_t first_nz(input logic [INPUT_COUNT-1:0] mask, input int from);
    idx_t pos;
    pos = '0;
    for (int i = INPUT_COUNT-1; i >= 0; i--)
      if (mask[i] && i >= from) pos = idx_t'(i);
    return pos;
  endfunction

  function automatic logic any_nz(input logic [INPUT_COUNT-1:0] mask, input int from);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < INPUT_COUNT; i++)
      if (mask[i] && i >= from) hit = 1'b1;
    return hit;
  endfunction
`endif

  // The only path from s_* to s_ready is through m_ready on the final lane.
  assign bus.s_ready = (state == IDLE) | ((state == SEND) & bus.m_ready & m_last_q);
  assign load_now    = bus.s_valid & bus.s_ready;

  always_comb begin
    ld_idx   = '0;
    ld_last  = 1'b0;
    adv_idx  = '0;
    adv_last = 1'b0;
`ifdef MACRO_LANE_SERIALIZER_SKIP_ZERO_EN
    ld_mask   = '0;
    word_mask = '0;
    for (int i = 0; i < INPUT_COUNT; i++) begin
      ld_mask[i]   = |bus.s_data[i*INPUT_WIDTH +: INPUT_WIDTH];
      word_mask[i] = |word[i*INPUT_WIDTH +: INPUT_WIDTH];
    end
    // An all-zero word lands on lane 0 with nothing above it, so it is last.
    ld_idx   = first_nz(ld_mask, 0);
    ld_last  = ~any_nz(ld_mask, int'(ld_idx) + 1);
    adv_idx  = first_nz(word_mask, int'(idx) + 1);
    adv_last = ~any_nz(word_mask, int'(adv_idx) + 1);
`else
    ld_idx   = '0;
    ld_last  = (INPUT_COUNT == 1);
    adv_idx  = idx + 1'b1;
    adv_last = (adv_idx == idx_t'(INPUT_COUNT - 1));
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word      <= '0;
      idx       <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (load_now) begin
      state     <= SEND;
      word      <= bus.s_data;
      idx       <= ld_idx;
      m_valid_q <= 1'b1;
      m_data_q  <= lane_of(bus.s_data, ld_idx);
      m_last_q  <= ld_last;
    end else if (state == SEND && bus.m_ready) begin
      if (!m_last_q) begin
        idx      <= adv_idx;
        m_data_q <= lane_of(word, adv_idx);
        m_last_q <= adv_last;
      end else begin
        // Word finished with no follow-on word: return outputs to idle values.
        state     <= IDLE;
        idx       <= '0;
        m_valid_q <= 1'b0;
        m_data_q  <= '0;
        m_last_q  <= 1'b0;
      end
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_index = idx;
  assign bus.m_last  = m_last_q;
  assign bus.m_zero  = ~|m_data_q;
endmodule

// File: tb/tb_macro_lane_serializer.sv
module tb_macro_lane_serializer;
`ifdef MACRO_LANE_SERIALIZER_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  macro_lane_serializer_if #(.INPUT_WIDTH(4), .INPUT_COUNT(4)) bus4();
  macro_lane_serializer_if #(.INPUT_WIDTH(8), .INPUT_COUNT(1)) bus1();

  macro_lane_serializer #(.INPUT_WIDTH(4), .INPUT_COUNT(4)) u4 (
    .clk(clk), .reset(rst), .bus(bus4)
  );
  macro_lane_serializer #(.INPUT_WIDTH(8), .INPUT_COUNT(1)) u1 (
    .clk(clk), .reset(rst), .bus(bus1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: word -> list of expected beats ----------
  typedef struct {
    logic [3:0] d;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  beat_t q[$];

  task automatic push_word(input logic [15:0] w);
    beat_t b[$];
    beat_t t;
    for (int i = 0; i < 4; i++) begin
      t.d    = 4'((w >> (4 * i)) & 16'hF);
      t.idx  = 2'(i);
      t.last = 1'b0;
      if (!SKIP || t.d != 4'h0) b.push_back(t);
    end
    if (b.size() == 0) begin
      t.d = 4'h0; t.idx = 2'd0; t.last = 1'b0;
      b.push_back(t);
    end
    for (int i = 0; i < b.size(); i++) begin
      t = b[i];
      t.last = (i == b.size() - 1);
      q.push_back(t);
    end
  endtask

  // Scoreboard monitor: inputs only change just after posedge, so the values
  // seen at negedge are exactly what the next posedge will act on.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("mon_m_valid", 32'(bus4.m_valid), 32'(q.size() != 0));
      chk("mon_s_ready", 32'(bus4.s_ready),
          32'((q.size() == 0) || (bus4.m_ready && q.size() == 1)));
      if (bus4.m_valid && q.size() != 0) begin
        chk("mon_m_data",  32'(bus4.m_data),  32'(q[0].d));
        chk("mon_m_index", 32'(bus4.m_index), 32'(q[0].idx));
        chk("mon_m_last",  32'(bus4.m_last),  32'(q[0].last));
        chk("mon_m_zero",  32'(bus4.m_zero),  32'(q[0].d == 4'h0));
        if (bus4.m_ready) void'(q.pop_front());
      end
      if (bus4.s_valid && bus4.s_ready) push_word(bus4.s_data);
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0]     w;
    int              n;
    logic [3:0][3:0] d;
    logic [3:0][1:0] ix;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input string tag);
    int k = 0;
    int guard = 0;
    bus4.m_ready = 1'b1;
    bus4.s_valid = 1'b1;
    bus4.s_data  = v.w;
    @(negedge clk);
    chk({tag, "_s_ready_idle"}, 32'(bus4.s_ready), 32'd1);
    chk({tag, "_m_valid_pre"},  32'(bus4.m_valid), 32'd0);
    @(posedge clk); #1;
    bus4.s_valid = 1'b0;
    bus4.s_data  = 16'($urandom);
    while (guard < 12) begin
      @(negedge clk);
      guard++;
      if (bus4.m_valid) begin
        if (k == 0) chk({tag, "_latency"}, 32'(guard), 32'd1);
        if (k < 4) begin
          chk({tag, "_data"},  32'(bus4.m_data),  32'(v.d[k]));
          chk({tag, "_index"}, 32'(bus4.m_index), 32'(v.ix[k]));
          chk({tag, "_last"},  32'(bus4.m_last),  32'(k == v.n - 1));
          chk({tag, "_zero"},  32'(bus4.m_zero),  32'(v.d[k] == 4'h0));
        end
        k++;
        if (bus4.m_last) break;
      end
    end
    chk({tag, "_beats"}, 32'(k), 32'(v.n));
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] exp3 [8];
    int guard;
    logic [7:0] w1;

    if (SKIP) begin
      vecs[0] = '{w:16'hA5C3, n:4, d:16'hA5C3, ix:8'hE4};
      vecs[1] = '{w:16'h0F00, n:1, d:16'h000F, ix:8'h02};
      vecs[2] = '{w:16'h0000, n:1, d:16'h0000, ix:8'h00};
      vecs[3] = '{w:16'hF00F, n:2, d:16'h00FF, ix:8'h0C};
    end else begin
      vecs[0] = '{w:16'hA5C3, n:4, d:16'hA5C3, ix:8'hE4};
      vecs[1] = '{w:16'h1234, n:4, d:16'h1234, ix:8'hE4};
      vecs[2] = '{w:16'h0000, n:4, d:16'h0000, ix:8'hE4};
      vecs[3] = '{w:16'hF00F, n:4, d:16'hF00F, ix:8'hE4};
    end

    bus4.s_valid = 1'b0; bus4.s_data = '0; bus4.m_ready = 1'b0;
    bus1.s_valid = 1'b0; bus1.s_data = '0; bus1.m_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_m_valid", 32'(bus4.m_valid), 32'd0);
    chk("rst_m_index", 32'(bus4.m_index), 32'd0);
    chk("rst_m_data",  32'(bus4.m_data),  32'd0);
    chk("rst_m_last",  32'(bus4.m_last),  32'd0);
    chk("rst_m_zero",  32'(bus4.m_zero),  32'd1);
    chk("rst_s_ready", 32'(bus4.s_ready), 32'd1);
    @(posedge clk); #1;

    // Table-driven words with m_ready held high
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Stall on beat 1: outputs held, s_ready low
    bus4.s_valid = 1'b1; bus4.s_data = 16'hA5C3; bus4.m_ready = 1'b1;
    @(posedge clk); #1;
    bus4.s_valid = 1'b0;
    @(posedge clk); #1;
    bus4.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_m_valid", 32'(bus4.m_valid), 32'd1);
      chk("stall_m_data",  32'(bus4.m_data),  32'hC);
      chk("stall_m_index", 32'(bus4.m_index), 32'd1);
      chk("stall_s_ready", 32'(bus4.s_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus4.m_ready = 1'b1;
    guard = 0;
    while (guard < 8) begin
      @(negedge clk);
      guard++;
      if (bus4.m_valid && bus4.m_last) break;
    end
    chk("stall_drain_timeout", 32'(guard < 8), 32'd1);
    @(posedge clk); #1;

    // Back-to-back words, s_valid held high: 8 beats, no bubble
    exp3 = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};
    bus4.s_valid = 1'b1; bus4.s_data = 16'hA5C3; bus4.m_ready = 1'b1;
    @(posedge clk); #1;
    bus4.s_data = 16'h1234;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b2b_m_valid", 32'(bus4.m_valid), 32'd1);
      chk("b2b_m_data",  32'(bus4.m_data),  32'(exp3[k]));
      chk("b2b_m_index", 32'(bus4.m_index), 32'(k % 4));
      if (k == 3) chk("b2b_s_ready_last", 32'(bus4.s_ready), 32'd1);
      if (k == 2) chk("b2b_s_ready_mid",  32'(bus4.s_ready), 32'd0);
      @(posedge clk); #1;
      if (k == 3) bus4.s_valid = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle_after", 32'(bus4.m_valid), 32'd0);
    @(posedge clk); #1;

    // Reset in the middle of beat 2
    bus4.s_valid = 1'b1; bus4.s_data = 16'hA5C3; bus4.m_ready = 1'b1;
    @(posedge clk); #1;
    bus4.s_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_pre_index", 32'(bus4.m_index), 32'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_valid", 32'(bus4.m_valid), 32'd0);
    chk("midrst_s_ready", 32'(bus4.s_ready), 32'd1);
    chk("midrst_m_index", 32'(bus4.m_index), 32'd0);
    chk("midrst_m_zero",  32'(bus4.m_zero),  32'd1);
    @(posedge clk); #1;
    run_vec(vecs[0], "after_rst");

    // Single-lane instance: every beat is last
    for (int i = 0; i < 2; i++) begin
      w1 = (i == 0) ? 8'h00 : 8'hA7;
      bus1.s_valid = 1'b1; bus1.s_data = w1; bus1.m_ready = 1'b1;
      @(negedge clk);
      chk("c1_s_ready_idle", 32'(bus1.s_ready), 32'd1);
      @(posedge clk); #1;
      bus1.s_valid = 1'b0;
      @(negedge clk);
      chk("c1_m_valid", 32'(bus1.m_valid), 32'd1);
      chk("c1_m_data",  32'(bus1.m_data),  32'(w1));
      chk("c1_m_zero",  32'(bus1.m_zero),  32'(w1 == 8'h00));
      chk("c1_m_last",  32'(bus1.m_last),  32'd1);
      chk("c1_m_index", 32'(bus1.m_index), 32'd0);
      chk("c1_s_ready_last", 32'(bus1.s_ready), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("c1_done", 32'(bus1.m_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      logic [15:0] w;
      w = '0;
      for (int l = 0; l < 4; l++)
        if ($urandom_range(0, 2) != 0) w[4*l +: 4] = 4'($urandom);
      bus4.s_valid = 1'($urandom_range(0, 1));
      bus4.s_data  = w;
      bus4.m_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    bus4.s_valid = 1'b0;
    bus4.m_ready = 1'b1;
    guard = 0;
    while (guard < 20) begin
      @(negedge clk);
      guard++;
      if (!bus4.m_valid) break;
    end
    chk("rand_drain", 32'(bus4.m_valid), 32'd0);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
